approx_mac_accum: RTL
=====================

Name: approx_mac_accum

Overview:
- Downstream consumer of the 16-bit approximate Wallace multiplier's 32-bit product.
- Accumulates a programmed number of products into a wide accumulator, one dot-product job at a time, for approximate-MAC / filter datapaths.
- Products arrive over a valid/ready handshake. The finished sum is offered on a second valid/ready output channel.

Parameters:
ACC_W, 40, accumulator/result width in bits (must be >= 33)
LEN_W, 8, width of the job-length field (max 2^LEN_W-1 products per job)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start_i  in  1  job start request; accepted only in IDLE
len_i  in  LEN_W  number of products in the job, sampled with accepted start_i
prod_i  in  32  product from the approximate multiplier, unsigned
prod_valid_i  in  1  prod_i valid
prod_ready_o  out  1  block accepts prod_i this cycle
acc_o  out  ACC_W  accumulated sum, registered
acc_valid_o  out  1  acc_o holds a finished job result
acc_ready_i  in  1  consumer takes acc_o
busy_o  out  1  high in any state other than IDLE
ovf_o  out  1  sticky per-job overflow flag, registered

Behaviour:
- Reset (async assert, sync deassert by the surrounding reset tree): state=IDLE; acc_o=0, acc_valid_o=0, prod_ready_o=0, busy_o=0, ovf_o=0, remaining counter=0.
- States: IDLE, ACC, DONE.
- IDLE:
  - prod_ready_o=0.
  - On start_i: clear acc_o, clear ovf_o, load remaining=len_i.
  - Next state is ACC if len_i!=0, else DONE (acc_o=0).
- ACC:
  - prod_ready_o=1.
  - Handshake = prod_valid_i & prod_ready_o. On handshake: acc_o <= acc_o + zero-extended prod_i; remaining <= remaining-1.
  - A handshake with remaining==1 moves to DONE.
  - No handshake: everything holds. Gaps in prod_valid_i are legal at any length.
- DONE:
  - acc_valid_o=1, prod_ready_o=0.
  - acc_o and ovf_o held stable while acc_ready_i=0.
  - When acc_ready_i=1: acc_valid_o drops next cycle and the state returns to IDLE.
- Latency: the handshake of the last product in cycle t gives acc_valid_o=1 in cycle t+1 with the final sum. len_i=0: start in cycle t gives acc_valid_o=1, acc_o=0 in cycle t+1.
- start_i outside IDLE is ignored; no queuing. Minimum one IDLE cycle between jobs.
- prod_i is accumulated at full 32 bits. The block does not rely on the multiplier's constant-zero low byte.
- Overflow (carry out of bit ACC_W-1): sum wraps modulo 2^ACC_W; ovf_o set and held until the next accepted start.
- Reset asserted mid-job: job abandoned, all outputs return to reset values immediately. No partial result is emitted.
- acc_valid_o never depends combinationally on acc_ready_i. prod_ready_o is a function of state only.

Optional Feature:
- Macro: APPROX_MAC_SATURATE_EN.
- Defined: on overflow, acc_o clamps to all-ones and stays there for the rest of the job. Further additions are ignored; ovf_o is set as usual.
- Undefined: modulo-2^ACC_W wrap as described above.

Decomposition:
- Shared package approx_mac_pkg holds:
  - state enum (IDLE, ACC, DONE)
  - PROD_W=32 constant
  - default ACC_W/LEN_W constants
- One sub-module is natural: approx_mac_acc_reg. It holds the adder, the overflow/saturation logic and the ACC_W accumulator register, with clear/enable inputs. The FSM and counter stay in the top.

Test Plan:
- len_i=3, products 100, 200, 300 with prod_valid_i continuous -> acc_valid_o high the cycle after the 3rd handshake; acc_o=600, ovf_o=0.
- len_i=0 -> one cycle after start, acc_valid_o=1, acc_o=0. No prod_ready_o pulse at any point.
- len_i=2, products 5 and 7 with a 4-cycle prod_valid_i gap, then acc_ready_i held low 6 cycles -> acc_o=12 stable and acc_valid_o=1 for all 6 cycles, prod_ready_o=0. Back to IDLE the cycle after acc_ready_i=1.
- ACC_W=33, len_i=3, three products 0xFFFFFFFF:
  - Wrap build -> acc_o=0x0FFFFFFFD, ovf_o=1.
  - APPROX_MAC_SATURATE_EN build -> acc_o=0x1FFFFFFFF, ovf_o=1.
  - The next job with len_i=1, prod 1 -> ovf_o=0, acc_o=1.
- start_i pulsed during ACC with a different len_i -> ignored; the original job's count completes unchanged.
- rst_n asserted after 2 of 4 products -> acc_o=0, acc_valid_o=0, busy_o=0 immediately. A fresh job after release computes correctly.

Source files
------------

// File: rtl/approx_mac_pkg.sv
// Shared types and constants for the approximate-MAC accumulator block.
package approx_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int PROD_W    = 32;
    localparam int ACC_W_DEF = 40;
    localparam int LEN_W_DEF = 8;

endpackage

// File: rtl/approx_mac_acc_reg.sv
// Wide accumulator register with adder and sticky overflow detection.
// APPROX_MAC_SATURATE_EN selects clamp-to-all-ones instead of modulo wrap.
module approx_mac_acc_reg
    import approx_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [PROD_W-1:0] add_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic              ovf_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum_ext;
    logic             carry;

    function automatic logic [ACC_W-1:0] sat_result(input logic [ACC_W:0] s);
        // Any carry out means the true sum no longer fits; pin to the ceiling.
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    always_comb begin
        sum_ext = {1'b0, acc_q} + {{(ACC_W - PROD_W + 1){1'b0}}, add_i};
        carry   = sum_ext[ACC_W];
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (en_i) begin
`ifdef APPROX_MAC_SATURATE_EN
            if (!ovf_q) begin
                acc_d = sat_result(sum_ext);
                ovf_d = carry;
            end
`else
            acc_d = sum_ext[ACC_W-1:0];
            ovf_d = ovf_q | carry;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/approx_mac_accum.sv
// Job-based accumulator for approximate-multiplier products: FSM, length counter
// and handshakes. Optional macro APPROX_MAC_SATURATE_EN enables saturation.
module approx_mac_accum
    import approx_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              prod_valid_i,
    output logic              prod_ready_o,
    output logic [ACC_W-1:0]  acc_o,
    output logic              acc_valid_o,
    input  logic              acc_ready_i,
    output logic              busy_o,
    output logic              ovf_o
);

    state_e           state_q;
    logic [LEN_W-1:0] rem_q;
    logic             prod_ready_q;
    logic             acc_valid_q;
    logic             busy_q;
    logic             job_start;
    logic             prod_hs;

    assign job_start = (state_q == ST_IDLE) && start_i;
    assign prod_hs   = prod_valid_i && prod_ready_q;

    // Handshake outputs are registered so they depend on state alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            prod_ready_q <= 1'b0;
            acc_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        rem_q  <= len_i;
                        busy_q <= 1'b1;
                        if (len_i != '0) begin
                            state_q      <= ST_ACC;
                            prod_ready_q <= 1'b1;
                        end else begin
                            state_q     <= ST_DONE;
                            acc_valid_q <= 1'b1;
                        end
                    end
                end
                ST_ACC: begin
                    if (prod_hs) begin
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == LEN_W'(1)) begin
                            state_q      <= ST_DONE;
                            prod_ready_q <= 1'b0;
                            acc_valid_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (acc_ready_i) begin
                        state_q     <= ST_IDLE;
                        acc_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    prod_ready_q <= 1'b0;
                    acc_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    approx_mac_acc_reg #(
        .ACC_W (ACC_W)
    ) u_acc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (job_start),
        .en_i  (prod_hs),
        .add_i (prod_i),
        .acc_o (acc_o),
        .ovf_o (ovf_o)
    );

    assign prod_ready_o = prod_ready_q;
    assign acc_valid_o  = acc_valid_q;
    assign busy_o       = busy_q;

endmodule
